// File: rtl/multicycle_sequencer.sv
// Main control FSM for the multi-cycle RV32I core: fetch handshake, instruction
// register, datapath strobes, retired-instruction counter and sticky halt.
module multicycle_sequencer #(
   parameter int unsigned INSTRET_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req,
   input  logic                     imem_ready,
   input  logic [31:0]              imem_rdata,
   output logic [31:0]              ir,
   input  logic                     branch_taken,
   output logic                     dmem_req,
   output logic                     dmem_we,
   input  logic                     dmem_ready,
   output logic                     rf_we,
   output logic                     pc_we,
   output logic [1:0]               pc_sel,
   output logic                     retire,
   output logic [INSTRET_WIDTH-1:0] instret,
   output logic                     halted,
   output logic [1:0]               halt_cause
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WAIT_W-1:0] TMO_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t                   r_state;
   logic [31:0]              r_ir;
   logic [INSTRET_WIDTH-1:0] r_instret;
   logic                     r_halted;
   logic [1:0]               r_cause;
   logic [WAIT_W-1:0]        r_waitCnt;

   logic [6:0] w_opcode;
   logic       w_isLoad;
   logic       w_isStore;
   logic       w_isBranch;
   logic       w_isJal;
   logic       w_isJalr;
   logic       w_isSystem;
   logic       w_isLegal;
   logic       w_timeout;
   logic       w_branchExec;
   logic       w_storeDone;
   logic       w_retire;

   assign w_opcode   = r_ir[6:0];
   assign w_isLoad   = (w_opcode == OP_LOAD);
   assign w_isStore  = (w_opcode == OP_STORE);
   assign w_isBranch = (w_opcode == OP_BRANCH);
   assign w_isJal    = (w_opcode == OP_JAL);
   assign w_isJalr   = (w_opcode == OP_JALR);
   assign w_isSystem = (w_opcode == OP_SYSTEM);
   assign w_isLegal  = w_isLoad || w_isStore || w_isBranch || w_isJal || w_isJalr ||
                       w_isSystem || (w_opcode == OP_OP) || (w_opcode == OP_OPIMM) ||
                       (w_opcode == OP_LUI) || (w_opcode == OP_AUIPC);

   // TIMEOUT_CYCLES low cycles are tolerated; a further low cycle is the bus error.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_waitCnt == TMO_LIMIT);

   assign w_branchExec = (r_state == S_EXECUTE) && w_isBranch;
   assign w_storeDone  = (r_state == S_MEMORY) && w_isStore && dmem_ready;
   assign w_retire     = w_branchExec || w_storeDone || (r_state == S_WRITEBACK);

   assign imem_req   = rst_n && (r_state == S_FETCH);
   assign dmem_req   = (r_state == S_MEMORY);
   assign dmem_we    = (r_state == S_MEMORY) && w_isStore;
   assign rf_we      = (r_state == S_WRITEBACK) && (r_ir[11:7] != 5'd0);
   assign pc_we      = w_retire;
   assign retire     = w_retire;
   assign ir         = r_ir;
   assign instret    = r_instret;
   assign halted     = r_halted;
   assign halt_cause = r_cause;

   always_comb begin
      pc_sel = 2'd0;
      if (w_branchExec && branch_taken) begin
         pc_sel = 2'd1;
      end else if (r_state == S_WRITEBACK) begin
         if (w_isJal) begin
            pc_sel = 2'd1;
         end else if (w_isJalr) begin
            pc_sel = 2'd2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_ir      <= 32'd0;
         r_instret <= '0;
         r_halted  <= 1'b0;
         r_cause   <= 2'd0;
         r_waitCnt <= '0;
      end else begin
         if (w_retire) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
         end
         case (r_state)
            S_FETCH: begin
               if (imem_ready) begin
                  r_ir    <= imem_rdata;
                  r_state <= S_DECODE;
               end else if (w_timeout) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= CAUSE_TIMEOUT;
               end else begin
                  r_waitCnt <= r_waitCnt + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               if (!w_isLegal) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= CAUSE_ILLEGAL;
               end else if (w_isSystem) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= CAUSE_SYSTEM;
               end else begin
                  r_state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               r_waitCnt <= '0;
               if (w_isBranch) begin
                  r_state <= S_FETCH;
               end else if (w_isLoad || w_isStore) begin
                  r_state <= S_MEMORY;
               end else begin
                  r_state <= S_WRITEBACK;
               end
            end
            S_MEMORY: begin
               if (dmem_ready) begin
                  r_waitCnt <= '0;
                  r_state   <= w_isLoad ? S_WRITEBACK : S_FETCH;
               end else if (w_timeout) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= CAUSE_TIMEOUT;
               end else begin
                  r_waitCnt <= r_waitCnt + WAIT_W'(1);
               end
            end
            S_WRITEBACK: begin
               r_waitCnt <= '0;
               r_state   <= S_FETCH;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: an instruction-level model
// produces the per-cycle expected outputs, a negedge process compares them.
module tb_multicycle_sequencer;

   localparam int IW  = 3;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          imem_req;
   logic          imem_ready = 1'b0;
   logic [31:0]   imem_rdata = 32'd0;
   logic [31:0]   ir;
   logic          branch_taken = 1'b0;
   logic          dmem_req;
   logic          dmem_we;
   logic          dmem_ready = 1'b0;
   logic          rf_we;
   logic          pc_we;
   logic [1:0]    pc_sel;
   logic          retire;
   logic [IW-1:0] instret;
   logic          halted;
   logic [1:0]    halt_cause;

   int checks = 0;
   int failures = 0;

   // Model state: architectural view of what the sequencer should hold
   logic [31:0] mIr = 32'd0;
   int          mInstret = 0;
   logic        mHalted = 1'b0;
   logic [1:0]  mCause = 2'd0;

   // Expected strobe values for the current cycle
   logic       expValid = 1'b0;
   logic       eImemReq = 1'b0;
   logic       eDmemReq = 1'b0;
   logic       eDmemWe = 1'b0;
   logic       eRfWe = 1'b0;
   logic       ePcWe = 1'b0;
   logic [1:0] ePcSel = 2'd0;
   logic       eRetire = 1'b0;

   multicycle_sequencer #(
      .INSTRET_WIDTH(IW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req(imem_req),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .ir(ir),
      .branch_taken(branch_taken),
      .dmem_req(dmem_req),
      .dmem_we(dmem_we),
      .dmem_ready(dmem_ready),
      .rf_we(rf_we),
      .pc_we(pc_we),
      .pc_sel(pc_sel),
      .retire(retire),
      .instret(instret),
      .halted(halted),
      .halt_cause(halt_cause)
   );

   always #5 clk = ~clk;

   // Single comparison point shared by the per-cycle compare and literal pins
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every meaningful cycle, the DUT outputs are held against the model
   always @(negedge clk) begin
      if (expValid) begin
         checkOutput("imem_req", 32'(imem_req), 32'(eImemReq));
         checkOutput("dmem_req", 32'(dmem_req), 32'(eDmemReq));
         checkOutput("dmem_we", 32'(dmem_we), 32'(eDmemWe));
         checkOutput("rf_we", 32'(rf_we), 32'(eRfWe));
         checkOutput("pc_we", 32'(pc_we), 32'(ePcWe));
         checkOutput("pc_sel", 32'(pc_sel), 32'(ePcSel));
         checkOutput("retire", 32'(retire), 32'(eRetire));
         checkOutput("ir", ir, mIr);
         checkOutput("instret", 32'(instret), 32'(mInstret));
         checkOutput("halted", 32'(halted), 32'(mHalted));
         checkOutput("halt_cause", 32'(halt_cause), 32'(mCause));
      end
   end

   // One clock cycle: publish expectations, step the clock, then account for retire
   task automatic applyStimulus(input logic iReq, input logic dReq, input logic dWe,
                                input logic rfWe, input logic pcWe, input logic [1:0] pcSel,
                                input logic ret);
      eImemReq = iReq;
      eDmemReq = dReq;
      eDmemWe  = dWe;
      eRfWe    = rfWe;
      ePcWe    = pcWe;
      ePcSel   = pcSel;
      eRetire  = ret;
      expValid = 1'b1;
      @(posedge clk);
      #1;
      if (ret) mInstret = (mInstret + 1) % (1 << IW);
   endtask

   // Walks one instruction through the cycle schedule implied by its opcode
   task automatic runInstr(input logic [31:0] instr, input int iWait, input int dWait,
                           input logic taken);
      logic [6:0] op;
      logic       isLd, isSt, isBr, isSys, legal;
      logic [1:0] wbSel;
      op    = instr[6:0];
      isLd  = (op == 7'b0000011);
      isSt  = (op == 7'b0100011);
      isBr  = (op == 7'b1100011);
      isSys = (op == 7'b1110011);
      legal = isLd || isSt || isBr || isSys || (op == 7'b0110011) || (op == 7'b0010011) ||
              (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111) ||
              (op == 7'b1100111);
      wbSel = (op == 7'b1101111) ? 2'd1 : ((op == 7'b1100111) ? 2'd2 : 2'd0);
      branch_taken = 1'b1;
      imem_ready = 1'b0;
      for (int k = 0; k < iWait; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 2'd0, 0);
         if (k == TMO) begin
            mHalted = 1'b1;
            mCause  = 2'd3;
            return;
         end
      end
      imem_ready = 1'b1;
      imem_rdata = instr;
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 0);
      mIr = instr;
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 0);
      if (!legal) begin
         mHalted = 1'b1;
         mCause  = 2'd2;
         return;
      end
      if (isSys) begin
         mHalted = 1'b1;
         mCause  = 2'd1;
         return;
      end
      if (isBr) begin
         branch_taken = taken;
         applyStimulus(0, 0, 0, 0, 1, {1'b0, taken}, 1);
         branch_taken = 1'b1;
         return;
      end
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 0);
      if (isLd || isSt) begin
         dmem_ready = 1'b0;
         for (int k = 0; k < dWait; k++) begin
            applyStimulus(0, 1, isSt, 0, 0, 2'd0, 0);
            if (k == TMO) begin
               mHalted = 1'b1;
               mCause  = 2'd3;
               return;
            end
         end
         dmem_ready = 1'b1;
         applyStimulus(0, 1, isSt, 0, isSt, 2'd0, isSt);
         dmem_ready = 1'b0;
         if (isSt) return;
      end
      applyStimulus(0, 0, 0, (instr[11:7] != 5'd0), 1, wbSel, 1);
   endtask

   // Halt must absorb every input pattern, including ready pulses
   task automatic haltCycles(input int n);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 2'd0, 0);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   // Holds reset across a clock edge, pins the reset values, then releases
   task automatic applyReset();
      expValid   = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_retire", 32'(retire), 32'd0);
      checkOutput("rst_ir", ir, 32'd0);
      checkOutput("rst_instret", 32'(instret), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mIr      = 32'd0;
      mInstret = 0;
      mHalted  = 1'b0;
      mCause   = 2'd0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      applyReset();

      runInstr(32'h00500093, 0, 0, 1'b0);
      checkOutput("pin_addi_ir", ir, 32'h00500093);
      checkOutput("pin_addi_instret", 32'(instret), 32'd1);

      runInstr(32'h0000A103, 0, 2, 1'b0);
      runInstr(32'h0020A023, 0, 0, 1'b0);
      runInstr(32'h00208463, 0, 0, 1'b1);
      checkOutput("pin_store_branch_instret", 32'(instret), 32'd4);
      runInstr(32'h000080E7, 0, 0, 1'b0);
      runInstr(32'h0000006F, 0, 0, 1'b0);
      runInstr(32'h00208463, 0, 0, 1'b0);
      runInstr(32'h00500093, 3, 0, 1'b0);
      checkOutput("pin_instret_wrap", 32'(instret), 32'd0);
      runInstr(32'h123450B7, 0, 0, 1'b0);
      runInstr(32'h00000117, 1, 0, 1'b0);
      runInstr(32'h0000A103, 0, TMO, 1'b0);
      runInstr(32'h0020A023, 2, 1, 1'b0);

      runInstr(32'hFFFFFFFF, 0, 0, 1'b0);
      haltCycles(4);
      checkOutput("pin_illegal_cause", 32'(halt_cause), 32'd2);
      checkOutput("pin_illegal_halted", 32'(halted), 32'd1);

      applyReset();
      runInstr(32'h00000073, 0, 0, 1'b0);
      haltCycles(3);
      checkOutput("pin_ecall_cause", 32'(halt_cause), 32'd1);

      applyReset();
      runInstr(32'h0000A103, 0, 99, 1'b0);
      haltCycles(3);
      checkOutput("pin_dmem_timeout_cause", 32'(halt_cause), 32'd3);

      applyReset();
      runInstr(32'h00500093, 99, 0, 1'b0);
      haltCycles(3);
      checkOutput("pin_imem_timeout_cause", 32'(halt_cause), 32'd3);

      // Reset dropped mid-MEMORY must clear everything without waiting for a clock
      applyReset();
      runInstr(32'h00500093, 0, 0, 1'b0);
      imem_ready = 1'b1;
      imem_rdata = 32'h0000A103;
      applyStimulus(1, 0, 0, 0, 0, 2'd0, 0);
      mIr = 32'h0000A103;
      imem_ready = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'd0, 0);
      expValid = 1'b0;
      #2;
      checkOutput("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("async_imem_req", 32'(imem_req), 32'd0);
      checkOutput("async_retire", 32'(retire), 32'd0);
      checkOutput("async_ir", ir, 32'd0);
      checkOutput("async_instret", 32'(instret), 32'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mIr      = 32'd0;
      mInstret = 0;
      mHalted  = 1'b0;
      mCause   = 2'd0;
      runInstr(32'h00500093, 0, 0, 1'b0);
      checkOutput("pin_resume_instret", 32'(instret), 32'd1);

      expValid = 1'b0;
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
